// File: rtl/t_vga_v1_nios2data_pkg.sv
// Shared definitions for the Nios II to VGA data bridge: register map,
// STATUS/CONTROL bit positions, data widths and read-word packing helpers.
package t_vga_v1_nios2data_pkg;

   localparam int DATA_W = 16;
   localparam int BUS_W  = 32;

   // Avalon-MM word addresses
   typedef enum logic [1:0] {
      REG_DATA    = 2'd0,
      REG_STATUS  = 2'd1,
      REG_CONTROL = 2'd2,
      REG_RSVD    = 2'd3
   } reg_addr_e;

   // STATUS layout
   localparam int ST_EMPTY_BIT = 0;
   localparam int ST_FULL_BIT  = 1;
   localparam int ST_OVF_BIT   = 2;
   localparam int ST_LEVEL_LSB = 3;
   localparam int ST_LEVEL_W   = 5;

   // CONTROL layout (FLUSH is write-only and always reads back as 0)
   localparam int CTL_EN_BIT    = 0;
   localparam int CTL_FLUSH_BIT = 1;
   localparam int CTL_IE_BIT    = 2;

   function automatic logic [BUS_W-1:0] pack_status(
      input logic [ST_LEVEL_W-1:0] level,
      input logic                  ovf,
      input logic                  full,
      input logic                  empty
   );
      logic [BUS_W-1:0] w;
      w = '0;
      w[ST_LEVEL_LSB +: ST_LEVEL_W] = level;
      w[ST_OVF_BIT]                 = ovf;
      w[ST_FULL_BIT]                = full;
      w[ST_EMPTY_BIT]               = empty;
      return w;
   endfunction

   function automatic logic [BUS_W-1:0] pack_control(
      input logic ie,
      input logic en
   );
      logic [BUS_W-1:0] w;
      w = '0;
      w[CTL_IE_BIT] = ie;
      w[CTL_EN_BIT] = en;
      return w;
   endfunction

endpackage

// File: rtl/t_vga_v1_nios2data_fifo.sv
// Word FIFO between the Avalon-MM DATA register and the fabric stream.
// Pointers wrap modulo DEPTH (power of two); level saturates in 0..DEPTH.
// Flush has priority over push and pop. Head word reads as 0 while empty.
module t_vga_v1_nios2data_fifo
   import t_vga_v1_nios2data_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [DATA_W-1:0]     din,
   output logic [DATA_W-1:0]     dout,
   output logic [ST_LEVEL_W-1:0] level,
   output logic                  full,
   output logic                  empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [ST_LEVEL_W-1:0] level_q, level_d;
   logic                  do_push, do_pop;

   assign full  = (level_q == ST_LEVEL_W'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   // Qualify push/pop and compute next pointers and level.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      do_pop   = pop && !empty && !flush;
      do_push  = push && !flush && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop)      level_d = level_q + ST_LEVEL_W'(1);
         else if (do_pop && !do_push) level_d = level_q - ST_LEVEL_W'(1);
      end
   end

   // Pointer and level registers with synchronous reset.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage write port.
   // NOTE: the array has no reset; stale words are never visible because dout is masked while empty.
   always_ff @(posedge clk) begin
      if (!reset && do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/t_vga_v1_nios2data.sv
// Avalon-MM slave that feeds 16-bit words from a Nios II into a small FIFO
// drained by a valid/ready fabric stream. Registers: DATA, STATUS, CONTROL.
// Optional feature: define T_VGA_V1_NIOS2DATA_IRQ_EN to add a registered irq
// output (OVF or IE-and-empty) and a writable IE bit; otherwise IE reads 0.
module t_vga_v1_nios2data
   import t_vga_v1_nios2data_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [BUS_W-1:0]  writedata,
   output logic [BUS_W-1:0]  readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
`ifdef T_VGA_V1_NIOS2DATA_IRQ_EN
   ,
   output logic              irq
`endif
);

   reg_addr_e             addr;
   logic                  bus_wr, data_wr, st_wr, ctl_wr;
   logic                  push, pop, flush, ovf_set;
   logic                  fifo_full, fifo_empty;
   logic [ST_LEVEL_W-1:0] fifo_level;

   logic                  en_q, en_d;
   logic                  ie_q, ie_d;
   logic                  ovf_q, ovf_d;
   logic [DATA_W-1:0]     last_q, last_d;
   logic [BUS_W-1:0]      readdata_q, readdata_d;
   logic                  unused_wdata;

   assign addr    = reg_addr_e'(address);
   assign bus_wr  = chipselect && !write_n;
   assign data_wr = bus_wr && (addr == REG_DATA);
   assign st_wr   = bus_wr && (addr == REG_STATUS);
   assign ctl_wr  = bus_wr && (addr == REG_CONTROL);

   // Stream handshake: a word leaves only while enabled and present at cycle start.
   assign out_valid = en_q && !fifo_empty;
   assign pop       = out_valid && out_ready;

   // A write into a full FIFO is still accepted when the head leaves in the same cycle.
   assign push    = data_wr && (!fifo_full || pop);
   assign ovf_set = data_wr && fifo_full && !pop;
   assign flush   = ctl_wr && writedata[CTL_FLUSH_BIT];

   assign readdata     = readdata_q;
   assign unused_wdata = ^writedata[BUS_W-1:DATA_W];

   t_vga_v1_nios2data_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (writedata[DATA_W-1:0]),
      .dout  (out_data),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state for control/status registers and the registered read mux.
   always_comb begin
      en_d       = en_q;
      ie_d       = ie_q;
      ovf_d      = ovf_q;
      last_d     = last_q;
      readdata_d = '0;

      if (ctl_wr) begin
         en_d = writedata[CTL_EN_BIT];
`ifdef T_VGA_V1_NIOS2DATA_IRQ_EN
         ie_d = writedata[CTL_IE_BIT];
`endif
      end
`ifndef T_VGA_V1_NIOS2DATA_IRQ_EN
      ie_d = 1'b0;
`endif

      if (push) last_d = writedata[DATA_W-1:0];

      // A fresh overflow beats a clear request in the same cycle.
      if (ovf_set)                               ovf_d = 1'b1;
      else if (st_wr && writedata[ST_OVF_BIT])   ovf_d = 1'b0;

      case (addr)
         REG_DATA:    readdata_d = {{(BUS_W-DATA_W){1'b0}}, last_q};
         REG_STATUS:  readdata_d = pack_status(fifo_level, ovf_q, fifo_full, fifo_empty);
         REG_CONTROL: readdata_d = pack_control(ie_q, en_q);
         default:     readdata_d = '0;
      endcase
   end

   // Control/status registers and read data, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         en_q       <= 1'b0;
         ie_q       <= 1'b0;
         ovf_q      <= 1'b0;
         last_q     <= '0;
         readdata_q <= '0;
      end else begin
         en_q       <= en_d;
         ie_q       <= ie_d;
         ovf_q      <= ovf_d;
         last_q     <= last_d;
         readdata_q <= readdata_d;
      end
   end

`ifdef T_VGA_V1_NIOS2DATA_IRQ_EN
   logic irq_q, irq_d;

   assign irq_d = ovf_q || (ie_q && fifo_empty);
   assign irq   = irq_q;

   // Registered interrupt request.
   always_ff @(posedge clk) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= irq_d;
   end
`endif

endmodule

// File: tb/tb_t_vga_v1_nios2data.sv
// Self-checking bench for t_vga_v1_nios2data (DEPTH=4). Stimulus issues bus
// writes, register reads and fabric ready; expected stream words and read
// words go into queues that a negedge monitor pops and compares.
module tb_t_vga_v1_nios2data;

   localparam int         DEPTH     = 4;
   localparam logic [1:0] A_DATA    = 2'd0;
   localparam logic [1:0] A_STATUS  = 2'd1;
   localparam logic [1:0] A_CONTROL = 2'd2;
   localparam logic [1:0] A_RSVD    = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
`ifdef T_VGA_V1_NIOS2DATA_IRQ_EN
   logic        irq;
`endif

   typedef struct {
      logic [31:0] exp;
      int          due;
      string       name;
   } rd_exp_t;

   rd_exp_t     rd_q[$];
   logic [15:0] out_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;

   t_vga_v1_nios2data #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
`ifdef T_VGA_V1_NIOS2DATA_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares stream words on handshakes and read words when due.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (out_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pop: got 0x%04h with no word expected (t=%0t)", out_data, $time);
         end else begin
            check("out_data", {16'h0, out_data}, {16'h0, out_q.pop_front()});
         end
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
         rd_exp_t e;
         e = rd_q.pop_front();
         check(e.name, readdata, e.exp);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      step(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd_reg(input logic [1:0] a, input logic [31:0] exp, input string name);
      rd_exp_t e;
      address = a;
      e.exp   = exp;
      e.due   = cyc + 1;
      e.name  = name;
      rd_q.push_back(e);
      step(1);
   endtask

   initial begin
      reset      = 1'b1;
      address    = A_DATA;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      out_ready  = 1'b0;
      step(3);
      reset = 1'b0;

      // Reset state
      check("rst_readdata", readdata, 32'h0);
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_out_data", {16'h0, out_data}, 32'h0);
      rd_reg(A_STATUS, 32'h1, "rst_status");
      rd_reg(A_CONTROL, 32'h0, "rst_control");
      rd_reg(A_DATA, 32'h0, "rst_data");

      // Single word pass-through with EN=1
      out_ready = 1'b1;
      bus_wr(A_CONTROL, 32'h1);
      out_q.push_back(16'h1234);
      bus_wr(A_DATA, 32'h1234);
      check("t1_valid_rise", {31'h0, out_valid}, 32'h1);
      check("t1_head", {16'h0, out_data}, 32'h1234);
      step(1);
      check("t1_valid_drained", {31'h0, out_valid}, 32'h0);
      rd_reg(A_STATUS, 32'h1, "t1_status");
      out_ready = 1'b0;

      // Overfill with EN=0: A0..A3 kept, A4 dropped
      bus_wr(A_CONTROL, 32'h0);
      for (int i = 0; i < 5; i++) begin
         if (i < DEPTH) out_q.push_back(16'hA0 + 16'(i));
         bus_wr(A_DATA, 32'hA0 + 32'(i));
      end
      // level 4 (0x20) | OVF (0x4) | full (0x2)
      rd_reg(A_STATUS, 32'h26, "t2_status");
      rd_reg(A_DATA, 32'hA3, "t2_data");
      check("t2_valid_en0", {31'h0, out_valid}, 32'h0);
      check("t2_head", {16'h0, out_data}, 32'hA0);

      // Full FIFO: write coincident with pop is accepted, no overflow
      bus_wr(A_STATUS, 32'h4);
      rd_reg(A_STATUS, 32'h22, "t3_ovf_cleared");
      bus_wr(A_CONTROL, 32'h1);
      out_ready = 1'b1;
      out_q.push_back(16'hBEEF);
      bus_wr(A_DATA, 32'hBEEF);
      out_ready = 1'b0;
      rd_reg(A_STATUS, 32'h22, "t3_status");
      rd_reg(A_DATA, 32'hBEEF, "t3_data");
      out_ready = 1'b1;
      step(4);
      out_ready = 1'b0;
      rd_reg(A_STATUS, 32'h1, "t3_drained");

      // Flush with 3 words queued and OVF set
      bus_wr(A_CONTROL, 32'h0);
      out_q.push_back(16'h11);
      for (int i = 1; i <= 5; i++) bus_wr(A_DATA, 32'(i * 'h11));
      bus_wr(A_CONTROL, 32'h1);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      // level 3 (0x18) | OVF (0x4)
      rd_reg(A_STATUS, 32'h1C, "t4_pre_flush");
      bus_wr(A_CONTROL, 32'h3);
      check("t4_valid_flushed", {31'h0, out_valid}, 32'h0);
      rd_reg(A_STATUS, 32'h5, "t4_post_flush");
      rd_reg(A_CONTROL, 32'h1, "t4_control");
      rd_reg(A_DATA, 32'h44, "t4_data");
      bus_wr(A_STATUS, 32'h4);
      rd_reg(A_STATUS, 32'h1, "t4_ovf_clr");

      // OVF: clear request followed by overflow leaves OVF set; later clear works
      bus_wr(A_CONTROL, 32'h0);
      for (int i = 0; i < DEPTH; i++) begin
         out_q.push_back(16'h61 + 16'(i));
         bus_wr(A_DATA, 32'h61 + 32'(i));
      end
      bus_wr(A_STATUS, 32'h4);
      bus_wr(A_DATA, 32'h65);
      rd_reg(A_STATUS, 32'h26, "t5_ovf_set");
      bus_wr(A_STATUS, 32'h0);
      rd_reg(A_STATUS, 32'h26, "t5_ovf_kept");
      bus_wr(A_STATUS, 32'h4);
      rd_reg(A_STATUS, 32'h22, "t5_ovf_clr");
      rd_reg(A_RSVD, 32'h0, "t5_reserved");
      bus_wr(A_CONTROL, 32'h1);
      out_ready = 1'b1;
      step(4);
      out_ready = 1'b0;
      rd_reg(A_STATUS, 32'h1, "t5_drained");

      // Interrupt enable
`ifdef T_VGA_V1_NIOS2DATA_IRQ_EN
      check("t6_irq_idle", {31'h0, irq}, 32'h0);
      bus_wr(A_CONTROL, 32'h5);
      step(1);
      check("t6_irq_empty", {31'h0, irq}, 32'h1);
      out_q.push_back(16'h77);
      bus_wr(A_DATA, 32'h77);
      check("t6_irq_lag", {31'h0, irq}, 32'h1);
      step(1);
      check("t6_irq_clear", {31'h0, irq}, 32'h0);
      rd_reg(A_CONTROL, 32'h5, "t6_control");
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
`else
      bus_wr(A_CONTROL, 32'h5);
      rd_reg(A_CONTROL, 32'h1, "t6_ie_forced0");
`endif

      // Reset mid-transfer with bus and fabric active
      bus_wr(A_CONTROL, 32'h0);
      bus_wr(A_DATA, 32'h71);
      bus_wr(A_DATA, 32'h72);
      bus_wr(A_CONTROL, 32'h1);
      reset      = 1'b1;
      out_ready  = 1'b1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = A_DATA;
      writedata  = 32'h99;
      step(1);
      reset      = 1'b0;
      out_ready  = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      check("t7_valid", {31'h0, out_valid}, 32'h0);
      check("t7_out_data", {16'h0, out_data}, 32'h0);
      check("t7_readdata", readdata, 32'h0);
      rd_reg(A_STATUS, 32'h1, "t7_status");
      rd_reg(A_DATA, 32'h0, "t7_data");
      rd_reg(A_CONTROL, 32'h0, "t7_control");

      // Bounded drain of outstanding expectations
      for (int i = 0; i < 20 && (out_q.size() > 0 || rd_q.size() > 0); i++) step(1);
      check("queues_drained", 32'(out_q.size() + rd_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
